// File: rtl/restoring_div_ctrl.sv
// Sequencer for an 8-bit unsigned restoring divider that produces one quotient
// bit per cycle through a single shared eight_bit_suber.

module eight_bit_suber (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] diff,
  output logic       borrow
);
  assign {borrow, diff} = {1'b0, a} - {1'b0, b};
endmodule

module restoring_div_ctrl #(
  parameter logic [7:0] ZERO_QUOT = 8'hFF,
  parameter int         NITER     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_dividend,
  input  logic [7:0] in_divisor,
  input  logic       flush,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_quot,
  output logic [7:0] out_rem,
  output logic       out_dbz
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] LAST_ITER = 3'(NITER - 1);

  state_t     state_q, state_d;
  logic [2:0] count_q, count_d;
  logic [7:0] r_q, r_d;
  logic [7:0] q_q, q_d;
  logic [7:0] dvs_q, dvs_d;
  logic [7:0] quot_q, quot_d;
  logic [7:0] rem_q, rem_d;
  logic       dbz_q, dbz_d;
  logic       in_ready_q, in_ready_d;
  logic       out_valid_q, out_valid_d;

  logic [8:0] shifted;
  logic [7:0] trial;
  logic       borrow;
  logic       take;
  logic [7:0] r_next;
  logic [7:0] q_next;

  assign shifted = {r_q, q_q[7]};

  eight_bit_suber u_suber (
    .a      (shifted[7:0]),
    .b      (dvs_q),
    .diff   (trial),
    .borrow (borrow)
  );

  // Shifted partial remainder is 9 bits wide; a set MSB always covers the divisor.
  assign take   = shifted[8] | ~borrow;
  assign r_next = take ? trial : shifted[7:0];
  assign q_next = {q_q[6:0], take};

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    r_d     = r_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            dvs_d = in_divisor;
            q_d   = in_dividend;
            r_d   = 8'd0;
            if (in_divisor == 8'd0) begin
              state_d = DONE;
              quot_d  = ZERO_QUOT;
              rem_d   = in_dividend;
              dbz_d   = 1'b1;
            end else begin
              state_d = RUN;
              count_d = 3'd0;
            end
          end else begin
            state_d = IDLE;
          end
        end
        RUN: begin
          r_d     = r_next;
          q_d     = q_next;
          count_d = count_q + 3'd1;
          if (count_q == LAST_ITER) begin
            state_d = DONE;
            quot_d  = q_next;
            rem_d   = r_next;
            dbz_d   = 1'b0;
          end else begin
            state_d = RUN;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end else begin
            state_d = DONE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= 3'd0;
      r_q         <= 8'd0;
      q_q         <= 8'd0;
      dvs_q       <= 8'd0;
      quot_q      <= 8'd0;
      rem_q       <= 8'd0;
      dbz_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      r_q         <= r_d;
      q_q         <= q_d;
      dvs_q       <= dvs_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      dbz_q       <= dbz_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_quot  = quot_q;
  assign out_rem   = rem_q;
  assign out_dbz   = dbz_q;

endmodule

// File: tb/tb_restoring_div_ctrl.sv
// Directed bench for restoring_div_ctrl: hand-computed divisions, handshake
// holds, flush/reset aborts and a short randomised sweep against a/b, a%b.

module tb_restoring_div_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_dividend;
  logic [7:0] in_divisor;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_quot;
  logic [7:0] out_rem;
  logic       out_dbz;

  int n_checks = 0;
  int n_fail   = 0;

  restoring_div_ctrl #(.ZERO_QUOT(8'hFF), .NITER(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_dividend (in_dividend),
    .in_divisor  (in_divisor),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_quot    (out_quot),
    .out_rem     (out_rem),
    .out_dbz     (out_dbz)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands for one edge; returns the number of edges until out_valid.
  task automatic start_div(input logic [7:0] a, input logic [7:0] b, output int lat);
    in_dividend = a;
    in_divisor  = b;
    in_valid    = 1'b1;
    step();
    in_valid    = 1'b0;
    in_dividend = 8'hA5;
    in_divisor  = 8'h5A;
    lat = 1;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic run_div(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input int eq, input int er, input int edbz, input int elat);
    int lat;
    start_div(a, b, lat);
    check_eq({tag, " latency"}, lat, elat);
    check_eq({tag, " quot"}, int'(out_quot), eq);
    check_eq({tag, " rem"}, int'(out_rem), er);
    check_eq({tag, " dbz"}, int'(out_dbz), edbz);
    check_eq({tag, " in_ready in DONE"}, int'(in_ready), 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq({tag, " out_valid after take"}, int'(out_valid), 0);
    check_eq({tag, " in_ready after take"}, int'(in_ready), 1);
    check_eq({tag, " quot kept"}, int'(out_quot), eq);
  endtask

  initial begin
    int lat;
    int a, b;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_dividend = 8'd0;
    in_divisor  = 8'd0;
    flush       = 1'b0;
    out_ready   = 1'b0;
    #12;
    check_eq("reset in_ready", int'(in_ready), 1);
    check_eq("reset out_valid", int'(out_valid), 0);
    check_eq("reset quot", int'(out_quot), 0);
    check_eq("reset rem", int'(out_rem), 0);
    check_eq("reset dbz", int'(out_dbz), 0);
    rst_n = 1'b1;
    step();

    run_div("200/7", 8'd200, 8'd7, 28, 4, 0, 9);

    // Back-to-back: in_ready must stay low while the first division runs.
    in_dividend = 8'd255;
    in_divisor  = 8'd1;
    in_valid    = 1'b1;
    step();
    in_valid = 1'b0;
    check_eq("255/1 in_ready low in RUN", int'(in_ready), 0);
    lat = 1;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    check_eq("255/1 latency", lat, 9);
    check_eq("255/1 quot", int'(out_quot), 255);
    check_eq("255/1 rem", int'(out_rem), 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    run_div("255/255", 8'd255, 8'd255, 1, 0, 0, 9);

    run_div("5/9", 8'd5, 8'd9, 0, 5, 0, 9);
    run_div("100/0", 8'd100, 8'd0, 255, 100, 1, 1);
    run_div("0/3", 8'd0, 8'd3, 0, 0, 0, 9);

    // Result held under back-pressure; in_valid ignored meanwhile.
    start_div(8'd200, 8'd7, lat);
    check_eq("hold latency", lat, 9);
    for (int i = 0; i < 20; i++) begin
      in_valid    = i[0];
      in_dividend = 8'(i * 13);
      in_divisor  = 8'(i);
      step();
      check_eq("hold out_valid", int'(out_valid), 1);
      check_eq("hold quot", int'(out_quot), 28);
      check_eq("hold rem", int'(out_rem), 4);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq("hold released", int'(out_valid), 0);

    // Asynchronous reset part-way through RUN.
    in_dividend = 8'd77;
    in_divisor  = 8'd5;
    in_valid    = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    #2 rst_n = 1'b0;
    #1;
    check_eq("async rst in_ready", int'(in_ready), 1);
    check_eq("async rst out_valid", int'(out_valid), 0);
    check_eq("async rst quot", int'(out_quot), 0);
    check_eq("async rst rem", int'(out_rem), 0);
    #3 rst_n = 1'b1;
    step();

    // Flush at RUN count=3: previous outputs must survive.
    run_div("9/2", 8'd9, 8'd2, 4, 1, 0, 9);
    in_dividend = 8'd250;
    in_divisor  = 8'd3;
    in_valid    = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_eq("flush in_ready", int'(in_ready), 1);
    check_eq("flush out_valid", int'(out_valid), 0);
    check_eq("flush quot kept", int'(out_quot), 4);
    check_eq("flush rem kept", int'(out_rem), 1);
    run_div("13/4", 8'd13, 8'd4, 3, 1, 0, 9);

    // Flush wins over out_ready in DONE.
    start_div(8'd50, 8'd6, lat);
    flush     = 1'b1;
    out_ready = 1'b1;
    step();
    flush     = 1'b0;
    out_ready = 1'b0;
    check_eq("flush in DONE out_valid", int'(out_valid), 0);
    check_eq("flush in DONE quot", int'(out_quot), 8);

    for (int k = 0; k < 300; k++) begin
      a = int'($urandom_range(0, 255));
      b = (k % 37 == 0) ? 0 : int'($urandom_range(1, 255));
      if (b == 0) begin
        run_div("rand dbz", 8'(a), 8'(b), 255, a, 1, 1);
      end else begin
        run_div("rand", 8'(a), 8'(b), a / b, a % b, 0, 9);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
